// File: rtl/milano_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : milano_prefetch_buffer
// Purpose  : Instruction-side producer for the milano decoder. Issues word
//            fetches to instruction memory, buffers returned words with their
//            PC in a DEPTH-entry FIFO and presents the head on a valid/ready
//            port. Flags heads whose opcode is not a known opcode. A branch
//            pulse flushes the buffer, drops in-flight responses and
//            redirects fetching.
// Revision : 1.0 - initial release
// ============================================================================
module milano_prefetch_buffer #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_rdata_o,
    output logic [31:0] fetch_addr_o,
    output logic        fetch_illegal_o,
    output logic        busy_o
);

    localparam int          PW          = $clog2(DEPTH);
    localparam int          CW          = PW + 1;
    localparam logic [31:0] C_BOOT_ADDR = {BOOT_ADDR[31:2], 2'b00};
    localparam logic [CW:0] C_DEPTH     = (CW+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    typedef enum logic [6:0] {
        OPCODE_LOAD     = 7'h03,
        OPCODE_MISC_MEM = 7'h0f,
        OPCODE_OP_IMM   = 7'h13,
        OPCODE_AUIPC    = 7'h17,
        OPCODE_STORE    = 7'h23,
        OPCODE_OP       = 7'h33,
        OPCODE_LUI      = 7'h37,
        OPCODE_BRANCH   = 7'h63,
        OPCODE_JALR     = 7'h67,
        OPCODE_JAL      = 7'h6f,
        OPCODE_SYSTEM   = 7'h73
    } opcode_e;

    function automatic logic opcode_legal(input logic [6:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OPCODE_LOAD, OPCODE_MISC_MEM, OPCODE_OP_IMM, OPCODE_AUIPC,
            OPCODE_STORE, OPCODE_OP, OPCODE_LUI, OPCODE_BRANCH,
            OPCODE_JALR, OPCODE_JAL, OPCODE_SYSTEM: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Registered state
    state_e          state_q,        state_d;
    logic [31:0]     fetch_pc_q,     fetch_pc_d;
    logic            branch_pend_q,  branch_pend_d;
    logic [31:0]     branch_tgt_q,   branch_tgt_d;
    logic [1:0]      outstanding_q,  outstanding_d;
    logic [1:0]      discard_q,      discard_d;
    logic [31:0]     rsp_pc_q [2];
    logic [31:0]     rsp_pc_d [2];
    logic [CW-1:0]   fifo_count_q,   fifo_count_d;
    logic [PW-1:0]   rd_ptr_q,       rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q,       wr_ptr_d;
    logic [31:0]     fifo_data_q [DEPTH];
    logic [31:0]     fifo_pc_q   [DEPTH];

    // Combinational helpers
    logic            w_is_req;
    logic            w_gnt;
    logic            w_rvalid;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_valid;
    logic            w_room;
    logic [1:0]      w_slot;
    logic [CW-1:0]   w_fifo_eff;
    logic [CW:0]     w_used;
    logic [31:0]     w_branch_tgt;
    logic            w_unused_branch_lsbs;

    assign w_branch_tgt         = {branch_addr_i[31:2], 2'b00};
    assign w_unused_branch_lsbs = ^branch_addr_i[1:0];

    // Handshake decode, occupancy bookkeeping and credit for the next request
    always_comb begin
        w_is_req     = (state_q == ST_REQ);
        w_gnt        = w_is_req & instr_gnt_i;
        // Responses are only meaningful while something is in flight
        w_rvalid     = instr_rvalid_i & (outstanding_q != 2'd0);
        // A branch in the same cycle drops the arriving response as well
        w_drop       = w_rvalid & ((discard_q != 2'd0) | branch_i);
        w_push       = w_rvalid & ~w_drop;
        w_fifo_valid = (fifo_count_q != '0);
        w_pop        = w_fifo_valid & fetch_ready_i & ~branch_i;

        outstanding_d = outstanding_q + {1'b0, w_gnt} - {1'b0, w_rvalid};

        // Occupancy seen by the credit check: a pop this cycle frees its slot,
        // a branch empties the buffer outright
        if (branch_i) begin
            w_fifo_eff = '0;
        end else begin
            w_fifo_eff = fifo_count_q - {{(CW-1){1'b0}}, w_pop};
        end
        w_used = {1'b0, w_fifo_eff}
               + {{(CW-1){1'b0}}, outstanding_q}
               + {{CW{1'b0}}, w_is_req};
        w_room = req_i & (outstanding_d != 2'd2) & (w_used < C_DEPTH);

        // Slot in the in-flight PC queue that a grant this cycle lands in
        w_slot = outstanding_q - {1'b0, w_rvalid};
    end

    // Request FSM, fetch address, branch redirect and discard tracking
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        branch_pend_d = branch_pend_q;
        branch_tgt_d  = branch_tgt_q;
        discard_d     = discard_q;

        case (state_q)
            ST_IDLE: begin
                if (w_room) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_gnt) begin
                    state_d = w_room ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_gnt) begin
            // A grant of a request raised before a redirect moves on to the target
            fetch_pc_d    = branch_pend_q ? branch_tgt_q : (fetch_pc_q + 32'd4);
            branch_pend_d = 1'b0;
        end

        if (branch_i) begin
            // Everything still in flight after this cycle belongs to the old stream
            discard_d = outstanding_d;
            if (w_is_req && !w_gnt) begin
                // Raised request must complete at its old address; redirect after it
                branch_pend_d = 1'b1;
                branch_tgt_d  = w_branch_tgt;
            end else begin
                branch_pend_d = 1'b0;
                fetch_pc_d    = w_branch_tgt;
            end
        end else begin
            discard_d = discard_q
                      - {1'b0, w_rvalid & (discard_q != 2'd0)}
                      + {1'b0, w_gnt & branch_pend_q};
        end
    end

    // In-flight PC queue (issue order) and FIFO pointer/count updates
    always_comb begin
        rsp_pc_d[0] = rsp_pc_q[0];
        rsp_pc_d[1] = rsp_pc_q[1];
        if (w_rvalid) begin
            rsp_pc_d[0] = rsp_pc_q[1];
        end
        if (w_gnt) begin
            if (w_slot[0]) begin
                rsp_pc_d[1] = fetch_pc_q;
            end else begin
                rsp_pc_d[0] = fetch_pc_q;
            end
        end

        fifo_count_d = fifo_count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        if (branch_i) begin
            fifo_count_d = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
        end else begin
            fifo_count_d = fifo_count_q + {{(CW-1){1'b0}}, w_push}
                         - {{(CW-1){1'b0}}, w_pop};
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    // Control and bookkeeping registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= C_BOOT_ADDR;
            branch_pend_q <= 1'b0;
            branch_tgt_q  <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            rsp_pc_q[0]   <= '0;
            rsp_pc_q[1]   <= '0;
            fifo_count_q  <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            branch_pend_q <= branch_pend_d;
            branch_tgt_q  <= branch_tgt_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            rsp_pc_q[0]   <= rsp_pc_d[0];
            rsp_pc_q[1]   <= rsp_pc_d[1];
            fifo_count_q  <= fifo_count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            fifo_data_q[wr_ptr_q] <= instr_rdata_i;
            fifo_pc_q[wr_ptr_q]   <= rsp_pc_q[0];
        end
    end

    assign instr_req_o     = w_is_req;
    assign instr_addr_o    = fetch_pc_q;
    assign fetch_valid_o   = w_fifo_valid;
    assign fetch_rdata_o   = w_fifo_valid ? fifo_data_q[rd_ptr_q] : 32'd0;
    assign fetch_addr_o    = w_fifo_valid ? fifo_pc_q[rd_ptr_q] : 32'd0;
    assign fetch_illegal_o = w_fifo_valid & ~opcode_legal(fetch_rdata_o[6:0]);
    assign busy_o          = w_is_req | (outstanding_q != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_milano_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_milano_prefetch_buffer
// Purpose  : Self-checking bench for milano_prefetch_buffer: opcode table plus
//            directed sequences for streaming, backpressure, branch flush,
//            stalled grant redirect, address wrap and mid-flight reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_milano_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr = 32'd0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        ready = 1'b0;

    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        fetch_valid_o;
    logic [31:0] fetch_rdata_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_illegal_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    logic        rsp_en = 1'b1;
    logic        fixed_en = 1'b0;
    logic [31:0] fixed_word = 32'd0;
    logic [31:0] mq [$];

    milano_prefetch_buffer #(.DEPTH(4), .BOOT_ADDR(32'h0000_0000)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (gnt),
        .instr_rvalid_i (rvalid),
        .instr_rdata_i  (rdata),
        .fetch_valid_o  (fetch_valid_o),
        .fetch_ready_i  (ready),
        .fetch_rdata_o  (fetch_rdata_o),
        .fetch_addr_o   (fetch_addr_o),
        .fetch_illegal_o(fetch_illegal_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[24:0], 7'h13};
    endfunction

    // Memory model: in-order, one cycle after grant, optionally held off
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            if (rvalid) void'(mq.pop_front());
            if (instr_req_o && gnt) mq.push_back(instr_addr_o);
        end
        #1;
        if (!rst && rsp_en && mq.size() > 0) begin
            rvalid = 1'b1;
            rdata  = fixed_en ? fixed_word : word_of(mq[0]);
        end else begin
            rvalid = 1'b0;
            rdata  = 32'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int maxc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (fetch_valid_o) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},     {31'd0, instr_req_o},     32'd0);
        chk({tag, "_addr"},    instr_addr_o,             32'd0);
        chk({tag, "_valid"},   {31'd0, fetch_valid_o},   32'd0);
        chk({tag, "_rdata"},   fetch_rdata_o,            32'd0);
        chk({tag, "_faddr"},   fetch_addr_o,             32'd0);
        chk({tag, "_illegal"}, {31'd0, fetch_illegal_o}, 32'd0);
        chk({tag, "_busy"},    {31'd0, busy_o},          32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_i = 1'b0;
        branch_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        exp_ill;
    } vec_t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [8];
        int          cyc;
        int          np;
        logic [31:0] got [8];
        logic [31:0] first_req;
        logic [31:0] first_vaddr;
        logic [31:0] first_vdata;
        logic        seen_req;
        logic        seen_val;
        logic [31:0] wrap_pc;

        tbl[0] = '{32'h0000_000B, 1'b1};
        tbl[1] = '{32'h0000_006F, 1'b0};
        tbl[2] = '{32'h0000_0000, 1'b1};
        tbl[3] = '{32'h0000_0013, 1'b0};
        tbl[4] = '{32'hFFFF_FF73, 1'b0};
        tbl[5] = '{32'h0000_007F, 1'b1};
        tbl[6] = '{32'h1234_5637, 1'b0};
        tbl[7] = '{32'h0000_0077, 1'b1};

        // ---- reset values ----
        gnt = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");

        // ---- 1: streaming, first-word latency ----
        rst = 1'b0; req_i = 1'b1; gnt = 1'b1; ready = 1'b0;
        @(negedge clk);
        chk("t1_req_c1",  {31'd0, instr_req_o}, 32'd1);
        chk("t1_addr_c1", instr_addr_o, 32'h0);
        @(negedge clk);
        chk("t1_addr_c2",  instr_addr_o, 32'h4);
        chk("t1_valid_c2", {31'd0, fetch_valid_o}, 32'd0);
        @(negedge clk);
        chk("t1_valid_c3", {31'd0, fetch_valid_o}, 32'd1);
        chk("t1_head_pc",  fetch_addr_o, 32'h0);
        chk("t1_head_data", fetch_rdata_o, 32'h0000_0013);
        chk("t1_illegal",  {31'd0, fetch_illegal_o}, 32'd0);

        // ---- 2: backpressure fills exactly DEPTH, then drains in order ----
        repeat (20) @(negedge clk);
        chk("t2_req_dropped", {31'd0, instr_req_o}, 32'd0);
        chk("t2_busy_idle",   {31'd0, busy_o}, 32'd0);
        chk("t2_head_pc",     fetch_addr_o, 32'h0);
        ready = 1'b1; req_i = 1'b0;
        np = 0;
        for (int i = 0; i < 8; i++) begin
            if (fetch_valid_o) begin
                if (np < 8) got[np] = fetch_addr_o;
                np++;
            end
            @(negedge clk);
        end
        chk("t2_pop_count", np, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_pop%0d_pc", i), got[i], 32'(i * 4));
        end

        // ---- 3: branch with two responses in flight ----
        req_i = 1'b1; rsp_en = 1'b0;
        @(negedge clk);
        chk("t3_addr_a", instr_addr_o, 32'h10);
        @(negedge clk);
        chk("t3_addr_b", instr_addr_o, 32'h14);
        @(negedge clk);
        chk("t3_req_stalled", {31'd0, instr_req_o}, 32'd0);
        chk("t3_busy_outst",  {31'd0, busy_o}, 32'd1);
        branch_i = 1'b1; branch_addr = 32'h0000_0203; rsp_en = 1'b1;
        @(negedge clk);
        branch_i = 1'b0;
        seen_req = 1'b0; seen_val = 1'b0;
        first_req = 32'hDEAD_BEEF; first_vaddr = 32'hDEAD_BEEF; first_vdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 12; i++) begin
            if (!seen_req && instr_req_o) begin
                seen_req = 1'b1; first_req = instr_addr_o;
            end
            if (!seen_val && fetch_valid_o) begin
                seen_val = 1'b1; first_vaddr = fetch_addr_o; first_vdata = fetch_rdata_o;
            end
            @(negedge clk);
        end
        chk("t3_first_req",   first_req,   32'h200);
        chk("t3_first_vaddr", first_vaddr, 32'h200);
        chk("t3_first_vdata", first_vdata, word_of(32'h200));

        // drain
        req_i = 1'b0;
        np = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy_o && !fetch_valid_o) break;
            np++;
            @(negedge clk);
        end
        chk("t3_drained", {31'd0, (busy_o | fetch_valid_o)}, 32'd0);

        // ---- 4: stalled grant with redirect mid-stall ----
        gnt = 1'b0; req_i = 1'b1; ready = 1'b0;
        branch_i = 1'b1; branch_addr = 32'h0000_0008;
        @(negedge clk);
        branch_i = 1'b0;
        chk("t4_req_c1",  {31'd0, instr_req_o}, 32'd1);
        chk("t4_addr_c1", instr_addr_o, 32'h8);
        @(negedge clk);
        chk("t4_addr_c2", instr_addr_o, 32'h8);
        branch_i = 1'b1; branch_addr = 32'h0000_0040;
        @(negedge clk);
        branch_i = 1'b0;
        chk("t4_addr_c3", instr_addr_o, 32'h8);
        @(negedge clk);
        chk("t4_addr_c4", instr_addr_o, 32'h8);
        @(negedge clk);
        chk("t4_addr_c5", instr_addr_o, 32'h8);
        gnt = 1'b1;
        @(negedge clk);
        chk("t4_req_after",  {31'd0, instr_req_o}, 32'd1);
        chk("t4_addr_after", instr_addr_o, 32'h40);
        wait_valid(10, cyc);
        chk("t4_valid_seen", {31'd0, (cyc > 0)}, 32'd1);
        chk("t4_head_pc",    fetch_addr_o, 32'h40);

        // ---- 5: opcode legality table ----
        fixed_en = 1'b1;
        for (int v = 0; v < 8; v++) begin
            gnt = 1'b1; ready = 1'b0; fixed_word = tbl[v].rdata;
            do_reset();
            req_i = 1'b1;
            wait_valid(10, cyc);
            chk($sformatf("t5_v%0d_latency", v), cyc, 32'd3);
            chk($sformatf("t5_v%0d_rdata", v),   fetch_rdata_o, tbl[v].rdata);
            chk($sformatf("t5_v%0d_illegal", v), {31'd0, fetch_illegal_o}, {31'd0, tbl[v].exp_ill});
        end
        fixed_en = 1'b0;

        // ---- 6a: address wrap ----
        gnt = 1'b1; ready = 1'b1;
        do_reset();
        req_i = 1'b1; branch_i = 1'b1; branch_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        branch_i = 1'b0;
        chk("t6_addr_top",  instr_addr_o, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("t6_addr_wrap", instr_addr_o, 32'h0);
        wait_valid(10, cyc);
        wrap_pc = 32'hFFFF_FFFC;
        chk("t6_head_top_pc",   fetch_addr_o,  wrap_pc);
        chk("t6_head_top_data", fetch_rdata_o, word_of(wrap_pc));
        @(negedge clk);
        chk("t6_head_wrap_valid", {31'd0, fetch_valid_o}, 32'd1);
        chk("t6_head_wrap_pc",    fetch_addr_o, 32'h0);

        // ---- 6b: reset with words buffered and a response in flight ----
        ready = 1'b0;
        do_reset();
        req_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6r_pre_valid", {31'd0, fetch_valid_o}, 32'd1);
        chk("t6r_pre_busy",  {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("t6r");
        rst = 1'b0;
        @(negedge clk);
        chk("t6r_refetch_req",  {31'd0, instr_req_o}, 32'd1);
        chk("t6r_refetch_addr", instr_addr_o, 32'h0);
        wait_valid(10, cyc);
        chk("t6r_head_pc",   fetch_addr_o,  32'h0);
        chk("t6r_head_data", fetch_rdata_o, 32'h0000_0013);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
